axis_header_inserter_gen: RTL and testbench
===========================================

Name: axis_header_inserter_gen

Overview:
Parametrised AXI-Stream header inserter, second generation. Prepends a variable-length single-beat header (0..DATA_BYTE_WD bytes) to a packet and re-packs the stream so every output beat is full except the last. Adds per-packet bypass, zero-length headers, a registered full-throughput output and keep-legality checking. Sits between the packet source and the downstream AXIS sink.

Parameters:
DATA_WD, 32, data bus width in bits; multiple of 8, ≥16.
DATA_BYTE_WD, DATA_WD/8, byte lanes; derived, not overridden.
CNT_WD, $clog2(DATA_BYTE_WD+1), width of byte counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_bypass  in  1  sampled on the header handshake; 1 = discard the header and pass the packet through
s00_axis_tvalid  in  1  header valid
s00_axis_tdata  in  DATA_WD  header; valid bytes are the low-order lanes
s00_axis_tkeep  in  DATA_BYTE_WD  header keep; contiguous ones from bit 0, all-zero allowed
s00_axis_tready  out  1  header ready
s01_axis_tvalid  in  1  data valid
s01_axis_tdata  in  DATA_WD  data; byte lane DATA_BYTE_WD-1 is first on the wire
s01_axis_tkeep  in  DATA_BYTE_WD  all ones, except the last beat: contiguous ones from the MSB, non-zero
s01_axis_tlast  in  1  end of packet
s01_axis_tready  out  1  data ready
m_axis_tvalid  out  1  output valid
m_axis_tdata  out  DATA_WD  output data, MSB-first
m_axis_tkeep  out  DATA_BYTE_WD  all ones except the last beat (contiguous from the MSB)
m_axis_tlast  out  1  end of packet
err_keep  out  1  sticky illegal-keep flag
busy  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state IDLE; residual cleared; m_axis_tvalid/tdata/tkeep/tlast = 0; err_keep = 0; busy = 0; s00_axis_tready = 0 while reset is asserted. A reset mid-packet aborts the packet with no flush.
- Residual register: res_data (DATA_WD) plus res_cnt (0..DATA_BYTE_WD). Bytes are left-aligned (the oldest byte sits in the MSB lane).
- FSM states:
  IDLE: s00_axis_tready=1, s01_axis_tready=0. On header handshake: H = popcount(tkeep), or 0 if cfg_bypass; res = header bytes left-aligned; res_cnt = H; go to STREAM.
  STREAM: s00_axis_tready=0; s01_axis_tready = !m_axis_tvalid || m_axis_tready. On data handshake with n = popcount(keep): C = res_cnt + n (≤ 2*DATA_BYTE_WD).
    - If C ≥ DATA_BYTE_WD: emit the top DATA_BYTE_WD bytes with keep all ones; res_cnt = C − DATA_BYTE_WD.
    - Else (only legal on tlast): emit C bytes, keep contiguous from the MSB, tlast=1, go to IDLE.
    - On tlast with C ≥ DATA_BYTE_WD: if residual = 0, tlast=1 on this beat and go to IDLE; otherwise go to FLUSH.
  FLUSH: s01_axis_tready=0. When the output slot is free, emit the residual with tlast=1, keep = res_cnt ones from the MSB; clear the residual; go to IDLE.
- Output register is loaded whenever it is empty or m_axis_tready=1. Latency is 1 cycle from data handshake to m_axis_tvalid. Steady-state throughput is 1 beat/clk.
- m_axis_tdata/tkeep/tlast hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- One-cycle header bubble per packet; the header is never accepted in the same cycle as data.
- Bypass or H=0: output equals input beat for beat, 1-cycle latency.
- Keep legality: err_keep is set on a handshake carrying an illegal keep (header not contiguous from bit 0; non-last data ≠ all ones; last data zero or not contiguous from the MSB). Framing still follows tlast; byte placement uses popcount and data content is unspecified.
- busy = (state != IDLE).

Decomposition:
- Shared package axis_ins_pkg holds: state enum (IDLE, STREAM, FLUSH), popcount function, keep-legality functions, and a mask-from-count function (MSB-aligned).
- One natural sub-module, axis_byte_packer: combinational merge of residual and beat into a 2*DATA_WD left-aligned concatenation plus count.

Test Plan:
1. DATA_WD=32. Header 0x00001122 keep 0011; data 0xA0A1A2A3, then 0xB0B1B2B3 (keep 1111, last) -> out 0x1122A0A1, 0xA2A3B0B1, then 0xB2B30000 keep 1100 tlast. The third beat comes from FLUSH.
2. Header 0x11223344 keep 1111; data 0xAABB0000 keep 1100 last -> out 0x11223344 keep 1111, then 0xAABB0000 keep 1100 tlast.
3. Header keep 0001 (0x44); data 0xAABBCC00 keep 1110 last -> single beat 0x44AABBCC keep 1111 tlast; back to IDLE without FLUSH.
4. cfg_bypass=1 or header keep 0000, 3-beat packet -> output identical to input, latency 1, header bytes absent.
5. 8 back-to-back packets with random m_axis_tready (50%) and random s01 valid gaps -> byte-exact match to the reference model; no drops or duplicates; outputs stable under stall; 1 beat/clk when unstalled.
6. Header keep 0101 -> err_keep=1 and remains sticky. Assert rst_n low mid-packet -> m_axis_tvalid=0 at once; after release busy=0, err_keep=0, and the next packet is correct.

Source files
------------

// File: rtl/axis_ins_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
//   state_t      : packet FSM states
//   popcnt       : number of set keep bits
//   mask_msb     : keep mask with cnt ones packed against the MSB of an nb-lane bus
//   keep_*_ok    : keep-legality predicates for header / full / last beats
// Helpers work on a MAX_BYTES-wide vector so one package serves any bus width;
// callers zero-extend on the way in and truncate on the way out.
package axis_ins_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  typedef logic [MAX_BYTES-1:0] kvec_t;

  function automatic logic [7:0] popcnt(input kvec_t k);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) c = c + {7'd0, k[i]};
    return c;
  endfunction

  function automatic kvec_t mask_msb(input int unsigned cnt, input int unsigned nb);
    kvec_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) m[i] = (i < nb) && (i + cnt >= nb);
    return m;
  endfunction

  // Header keep: contiguous ones from bit 0 (all-zero allowed).
  function automatic logic keep_hdr_ok(input kvec_t k);
    return (k & (k + kvec_t'(1))) == '0;
  endfunction

  function automatic logic keep_full_ok(input kvec_t k, input int unsigned nb);
    return k == mask_msb(nb, nb);
  endfunction

  // Last data keep: non-zero, contiguous ones from the MSB.
  function automatic logic keep_last_ok(input kvec_t k, input int unsigned nb);
    return (k != '0) && (k == mask_msb(32'(popcnt(k)), nb));
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Combinational merge of the left-aligned residual with an incoming beat.
//   i_res_data/i_res_cnt   : residual bytes, oldest in the MSB lane
//   i_beat_data/i_beat_keep: incoming beat, MSB-first
//   o_hi                   : first DATA_WD bits of the merged stream
//   o_lo                   : remainder, already left-aligned for reuse as residual
//   o_cnt                  : total valid bytes (0..2*DATA_BYTE_WD)
// Beat lanes are masked by popcount so the residual never carries stale bytes.
module axis_byte_packer
  import axis_ins_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic [DATA_WD-1:0]      i_res_data,
  input  logic [CNT_WD-1:0]       i_res_cnt,
  input  logic [DATA_WD-1:0]      i_beat_data,
  input  logic [DATA_BYTE_WD-1:0] i_beat_keep,
  output logic [DATA_WD-1:0]      o_hi,
  output logic [DATA_WD-1:0]      o_lo,
  output logic [CNT_WD:0]         o_cnt
);

  logic [DATA_BYTE_WD-1:0] w_bmask;
  logic [DATA_WD-1:0]      w_beat_m;
  logic [2*DATA_WD-1:0]    w_cat;

  assign w_bmask = DATA_BYTE_WD'(mask_msb(32'(popcnt(kvec_t'(i_beat_keep))), DATA_BYTE_WD));

  for (genvar g = 0; g < DATA_BYTE_WD; g++) begin : g_lane
    assign w_beat_m[8*g +: 8] = i_beat_data[8*g +: 8] & {8{w_bmask[g]}};
  end

  // Beat slides right past the residual bytes already occupying the top lanes.
  assign w_cat = {i_res_data, {DATA_WD{1'b0}}}
               | ({w_beat_m, {DATA_WD{1'b0}}} >> {i_res_cnt, 3'b000});

  assign o_hi  = w_cat[2*DATA_WD-1:DATA_WD];
  assign o_lo  = w_cat[DATA_WD-1:0];
  assign o_cnt = {1'b0, i_res_cnt} + (CNT_WD+1)'(popcnt(kvec_t'(i_beat_keep)));

endmodule

// File: rtl/axis_header_inserter_gen.sv
// AXI-Stream header inserter: prepends a 0..DATA_BYTE_WD byte header (s00) to a
// packet (s01) and re-packs so every output beat is full except the last.
//   clk, rst_n        : clock, async active-low reset
//   cfg_bypass        : sampled with the header; drops the header bytes
//   s00_axis_*        : header, valid bytes in the low lanes
//   s01_axis_*        : packet data, MSB lane first on the wire
//   m_axis_*          : registered output stream, MSB-first
//   err_keep          : sticky illegal-keep flag
//   busy              : packet in progress
module axis_header_inserter_gen
  import axis_ins_pkg::*;
#(
  parameter  int DATA_WD      = 32,
  localparam int DATA_BYTE_WD = DATA_WD / 8,
  localparam int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_bypass,
  input  logic                    s00_axis_tvalid,
  input  logic [DATA_WD-1:0]      s00_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s00_axis_tkeep,
  output logic                    s00_axis_tready,
  input  logic                    s01_axis_tvalid,
  input  logic [DATA_WD-1:0]      s01_axis_tdata,
  input  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WD-1:0]      m_axis_tdata,
  output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    err_keep,
  output logic                    busy
);

  localparam logic [CNT_WD:0] NB_C = (CNT_WD+1)'(DATA_BYTE_WD);

  state_t                  r_state;
  logic                    r_hdr_rdy;
  logic [DATA_WD-1:0]      r_res_data;
  logic [CNT_WD-1:0]       r_res_cnt;
  logic                    r_m_tvalid;
  logic [DATA_WD-1:0]      r_m_tdata;
  logic [DATA_BYTE_WD-1:0] r_m_tkeep;
  logic                    r_m_tlast;
  logic                    r_err;

  logic                    w_out_free, w_dat_rdy, w_hdr_hs, w_dat_hs;
  logic [CNT_WD-1:0]       w_h, w_rem;
  logic [31:0]             w_hshift;
  logic [DATA_WD-1:0]      w_hdr_al, w_hi, w_lo;
  logic [CNT_WD:0]         w_cnt;
  logic                    w_full, w_dkeep_ok, w_hkeep_ok;
  logic [DATA_BYTE_WD-1:0] w_keep_c, w_keep_r;

  axis_byte_packer #(
    .DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD), .CNT_WD(CNT_WD)
  ) u_packer (
    .i_res_data (r_res_data),
    .i_res_cnt  (r_res_cnt),
    .i_beat_data(s01_axis_tdata),
    .i_beat_keep(s01_axis_tkeep),
    .o_hi       (w_hi),
    .o_lo       (w_lo),
    .o_cnt      (w_cnt)
  );

  // Output slot can take a new beat this cycle.
  assign w_out_free = !r_m_tvalid || m_axis_tready;
  assign w_dat_rdy  = (r_state == STREAM) && w_out_free;
  assign w_hdr_hs   = s00_axis_tvalid && r_hdr_rdy;
  assign w_dat_hs   = s01_axis_tvalid && w_dat_rdy;

  // Header bytes move from the low lanes to the top lanes; H=0 shifts everything out.
  assign w_h      = cfg_bypass ? '0 : CNT_WD'(popcnt(kvec_t'(s00_axis_tkeep)));
  assign w_hshift = (32'(DATA_BYTE_WD) - 32'(w_h)) * 32'd8;
  assign w_hdr_al = s00_axis_tdata << w_hshift;

  assign w_full   = w_cnt >= NB_C;
  assign w_rem    = CNT_WD'(w_cnt - NB_C);
  assign w_keep_c = DATA_BYTE_WD'(mask_msb(32'(w_cnt), DATA_BYTE_WD));
  assign w_keep_r = DATA_BYTE_WD'(mask_msb(32'(r_res_cnt), DATA_BYTE_WD));

  assign w_hkeep_ok = keep_hdr_ok(kvec_t'(s00_axis_tkeep));
  assign w_dkeep_ok = s01_axis_tlast ? keep_last_ok(kvec_t'(s01_axis_tkeep), DATA_BYTE_WD)
                                     : keep_full_ok(kvec_t'(s01_axis_tkeep), DATA_BYTE_WD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hdr_rdy  <= 1'b0;
      r_res_data <= '0;
      r_res_cnt  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_out_free) r_m_tvalid <= 1'b0;
      if ((w_hdr_hs && !w_hkeep_ok) || (w_dat_hs && !w_dkeep_ok)) r_err <= 1'b1;

      case (r_state)
        IDLE: begin
          // Ready rises one cycle after reset release.
          if (!r_hdr_rdy) begin
            r_hdr_rdy <= 1'b1;
          end else if (s00_axis_tvalid) begin
            r_res_data <= w_hdr_al;
            r_res_cnt  <= w_h;
            r_hdr_rdy  <= 1'b0;
            r_state    <= STREAM;
          end
        end

        STREAM: begin
          if (w_dat_hs) begin
            if (w_full) begin
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_hi;
              r_m_tkeep  <= '1;
              r_m_tlast  <= 1'b0;
              r_res_data <= w_lo;
              r_res_cnt  <= w_rem;
              if (s01_axis_tlast) begin
                if (w_rem == '0) begin
                  r_m_tlast <= 1'b1;
                  r_state   <= IDLE;
                  r_hdr_rdy <= 1'b1;
                end else begin
                  r_state   <= FLUSH;
                end
              end
            end else if (s01_axis_tlast) begin
              r_m_tvalid <= 1'b1;
              r_m_tdata  <= w_hi;
              r_m_tkeep  <= w_keep_c;
              r_m_tlast  <= 1'b1;
              r_res_data <= '0;
              r_res_cnt  <= '0;
              r_state    <= IDLE;
              r_hdr_rdy  <= 1'b1;
            end else begin
              // Short non-last beat (illegal keep): keep accumulating, framing follows tlast.
              r_res_data <= w_hi;
              r_res_cnt  <= CNT_WD'(w_cnt);
            end
          end
        end

        FLUSH: begin
          if (w_out_free) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= r_res_data;
            r_m_tkeep  <= w_keep_r;
            r_m_tlast  <= 1'b1;
            r_res_data <= '0;
            r_res_cnt  <= '0;
            r_state    <= IDLE;
            r_hdr_rdy  <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign s00_axis_tready = r_hdr_rdy;
  assign s01_axis_tready = w_dat_rdy;
  assign m_axis_tvalid   = r_m_tvalid;
  assign m_axis_tdata    = r_m_tdata;
  assign m_axis_tkeep    = r_m_tkeep;
  assign m_axis_tlast    = r_m_tlast;
  assign err_keep        = r_err;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_axis_header_inserter_gen.sv
// Bench for axis_header_inserter_gen (DATA_WD=32). A byte-level model pushes
// expected output beats when a packet is driven; the output monitor pops and
// compares on each handshake and checks that stalled outputs hold steady.
module tb_axis_header_inserter_gen;

  localparam int DW = 32;
  localparam int NB = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_bypass = 1'b0;
  logic          s00_axis_tvalid = 1'b0;
  logic [DW-1:0] s00_axis_tdata = '0;
  logic [NB-1:0] s00_axis_tkeep = '0;
  logic          s00_axis_tready;
  logic          s01_axis_tvalid = 1'b0;
  logic [DW-1:0] s01_axis_tdata = '0;
  logic [NB-1:0] s01_axis_tkeep = '0;
  logic          s01_axis_tlast = 1'b0;
  logic          s01_axis_tready;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic [NB-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          err_keep;
  logic          busy;

  axis_header_inserter_gen #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tkeep(s00_axis_tkeep), .s00_axis_tready(s00_axis_tready),
    .s01_axis_tvalid(s01_axis_tvalid), .s01_axis_tdata(s01_axis_tdata),
    .s01_axis_tkeep(s01_axis_tkeep), .s01_axis_tlast(s01_axis_tlast),
    .s01_axis_tready(s01_axis_tready),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .err_keep(err_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
  int    gap_max = 0;
  int    t_first, t_last;
  beat_t expq[$];
  logic [DW-1:0] pd[16];
  logic [NB-1:0] pk[16];
  int    pn;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Output monitor: sampled at negedge, handshake completes at the next posedge.
  initial begin
    beat_t held, cur, b;
    logic  hp;
    hp = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{d: m_axis_tdata, k: m_axis_tkeep, l: m_axis_tlast};
      if (!rst_n || !m_axis_tvalid) begin
        hp = 1'b0;
      end else begin
        if (hp) begin
          n_cmp++;
          if (cur !== held) begin
            n_bad++;
            $display("FAIL stall_hold: got %h/%b/%b want %h/%b/%b",
                     cur.d, cur.k, cur.l, held.d, held.k, held.l);
          end
        end
        if (m_axis_tready) begin
          hp = 1'b0;
          n_cmp++;
          if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL extra_beat: got %h/%b/%b want none", cur.d, cur.k, cur.l);
          end else begin
            b = expq.pop_front();
            if (cur !== b) begin
              n_bad++;
              $display("FAIL out_beat: got %h/%b/%b want %h/%b/%b",
                       cur.d, cur.k, cur.l, b.d, b.k, b.l);
            end
          end
        end else begin
          hp = 1'b1;
          held = cur;
        end
      end
    end
  end

  // Byte-level reference: header bytes (lane H-1 first), then data bytes MSB lane first.
  task automatic model_push(input logic [DW-1:0] hdr, input logic [NB-1:0] hk, input logic byp);
    logic [7:0] bq[$];
    beat_t b;
    int h;
    h = byp ? 0 : $countones(hk);
    for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[8*i +: 8]);
    for (int j = 0; j < pn; j++)
      for (int i = NB - 1; i >= 0; i--)
        if (pk[j][i]) bq.push_back(pd[j][8*i +: 8]);
    while (bq.size() > 0) begin
      b = '0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (bq.size() > 0) begin
          b.d[8*i +: 8] = bq.pop_front();
          b.k[i] = 1'b1;
        end
      end
      b.l = (bq.size() == 0);
      expq.push_back(b);
    end
  endtask

  task automatic send_hdr(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic byp);
    int w;
    w = 0;
    s00_axis_tvalid = 1'b1; s00_axis_tdata = d; s00_axis_tkeep = k; cfg_bypass = byp;
    @(negedge clk);
    while (!s00_axis_tready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL hdr_timeout: got no s00 ready want ready within 200 cycles");
    end
    @(posedge clk);
    #1;
    s00_axis_tvalid = 1'b0; cfg_bypass = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
    int w;
    w = 0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    s01_axis_tvalid = 1'b1; s01_axis_tdata = d; s01_axis_tkeep = k; s01_axis_tlast = l;
    @(negedge clk);
    while (!s01_axis_tready && w < 500) begin @(negedge clk); w++; end
    if (w >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL data_timeout: got no s01 ready want ready within 500 cycles");
    end
    @(posedge clk);
    #1;
    s01_axis_tvalid = 1'b0; s01_axis_tlast = 1'b0;
  endtask

  task automatic run_pkt(input logic [DW-1:0] hdr, input logic [NB-1:0] hk,
                         input logic byp, input logic lat_chk);
    model_push(hdr, hk, byp);
    send_hdr(hdr, hk, byp);
    for (int j = 0; j < pn; j++) begin
      send_beat(pd[j], pk[j], j == pn - 1);
      if (j == 0) t_first = cyc;
      t_last = cyc;
      if (lat_chk) begin
        n_cmp++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd[j]) begin
          n_bad++;
          $display("FAIL latency1: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, pd[j]);
        end
      end
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (expq.size() > 0 && w < 2000) begin @(posedge clk); w++; end
    if (expq.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d beats missing want 0", expq.size());
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== '0) begin
      n_bad++; $display("FAIL reset_out: got v=%b d=%h k=%b l=%b want zeros",
                        m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    n_cmp++;
    if ({err_keep, busy, s00_axis_tready, s01_axis_tready} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctl: got err=%b busy=%b r0=%b r1=%b want 0000",
                        err_keep, busy, s00_axis_tready, s01_axis_tready);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (s00_axis_tready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ready: got %b want 1", s00_axis_tready);
    end
  endtask

  task automatic test_flush();
    pn = 2; pd[0] = 32'hA0A1A2A3; pk[0] = 4'hF; pd[1] = 32'hB0B1B2B3; pk[1] = 4'hF;
    run_pkt(32'h00001122, 4'b0011, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_state: got busy=%b want 1", busy); end
    wait_drain();
    pn = 1; pd[0] = 32'hAABB0000; pk[0] = 4'b1100;
    run_pkt(32'h11223344, 4'hF, 1'b0, 1'b0);
    wait_drain();
  endtask

  task automatic test_single_beat();
    pn = 1; pd[0] = 32'hAABBCC00; pk[0] = 4'b1110;
    run_pkt(32'h00000044, 4'b0001, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL no_flush: got busy=%b want 0", busy); end
    wait_drain();
  endtask

  task automatic test_bypass();
    logic [NB-1:0] hks[2];
    logic          bps[2];
    hks[0] = 4'hF; bps[0] = 1'b1;
    hks[1] = 4'h0; bps[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pn = 3;
      pd[0] = 32'h01020304; pk[0] = 4'hF;
      pd[1] = 32'h05060708; pk[1] = 4'hF;
      pd[2] = 32'h090A0000; pk[2] = 4'b1100;
      run_pkt(32'hDEADBEEF, hks[c], bps[c], 1'b1);
      n_cmp++;
      if (t_last - t_first !== 2) begin
        n_bad++; $display("FAIL throughput: got %0d cycles want 2", t_last - t_first);
      end
      wait_drain();
    end
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] lkt[4];
    logic [NB-1:0] hkt[5];
    logic [DW-1:0] hd;
    lkt[0] = 4'b1000; lkt[1] = 4'b1100; lkt[2] = 4'b1110; lkt[3] = 4'b1111;
    hkt[0] = 4'b0000; hkt[1] = 4'b0001; hkt[2] = 4'b0011; hkt[3] = 4'b0111; hkt[4] = 4'b1111;
    rdy_mode = 1; gap_max = 2;
    for (int p = 0; p < 8; p++) begin
      pn = $urandom_range(1, 5);
      for (int j = 0; j < pn; j++) begin
        pd[j] = $urandom;
        pk[j] = (j == pn - 1) ? lkt[$urandom_range(0, 3)] : 4'hF;
        for (int i = 0; i < NB; i++) if (!pk[j][i]) pd[j][8*i +: 8] = 8'h00;
      end
      hd = $urandom;
      run_pkt(hd, hkt[$urandom_range(0, 4)], $urandom_range(0, 4) == 0, 1'b0);
    end
    wait_drain();
    rdy_mode = 0; gap_max = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_err_and_reset();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_hdr(32'h55667788, 4'b0101, 1'b0);
    n_cmp++;
    if (err_keep !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err_keep); end
    send_beat(32'h12345678, 4'hF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err_keep !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_keep); end
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL pre_abort: got v=%b busy=%b want 1 1", m_axis_tvalid, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", m_axis_tvalid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || err_keep !== 1'b0) begin
      n_bad++; $display("FAIL post_reset: got busy=%b err=%b want 0 0", busy, err_keep);
    end
    @(posedge clk);
    #1;
    pn = 2; pd[0] = 32'hC0C1C2C3; pk[0] = 4'hF; pd[1] = 32'hD0D10000; pk[1] = 4'b1100;
    run_pkt(32'h000000EE, 4'b0001, 1'b0, 1'b0);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_flush();
    test_single_beat();
    test_bypass();
    test_back_to_back();
    test_err_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
